// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing: pixel strobe, x/y counters, registered decodes.
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high hsync/vsync (default active-low).
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [9:0] X_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS_END    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS_END    = 10'(V_DISPLAY);
  localparam logic [9:0] X_SYNC_START = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] X_SYNC_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] Y_SYNC_START = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] Y_SYNC_END   = 10'(V_DISPLAY + V_FP + V_SYNC);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_ACTIVE = 1'b1;
`else
  localparam logic SYNC_ACTIVE = 1'b0;
`endif
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             wrap_q, wrap_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             x_last;
  logic             y_last;

  assign tick   = (div_q == DIV_LAST);
  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  // Counters move only on the pixel strobe; decodes look at the current x/y every clk.
  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    x_d           = x_q;
    y_d           = y_q;
    if (tick) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    video_on_d    = (x_q < X_VIS_END) && (y_q < Y_VIS_END);
    hsync_d       = ((x_q >= X_SYNC_START) && (x_q < X_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
    vsync_d       = ((y_q >= Y_SYNC_START) && (y_q < Y_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
    // wrap_q marks the edge that landed on (0,0); frame_start follows it by one clk.
    wrap_d        = tick && x_last && y_last;
    frame_start_d = wrap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      wrap_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      wrap_q        <= wrap_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign p_tick      = tick;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: time-based raster model plus directed literal checks.
// Default horizontal timing, shortened vertical timing so whole frames fit in the run.
module tb_vga_timing_gen;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int HT = HD + HF + HS + HB;
  localparam int VD = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VD + VF + VS + VB;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SA = 1'b1;
`else
  localparam logic SA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xA, yA, xB, yB;
  logic       vidA, hsA, vsA, ptA, fsA;
  logic       vidB, hsB, vsB, ptB, fsB;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TICK_DIV(2)
  ) dutA (
    .clk(clk), .reset(reset), .x(xA), .y(yA), .video_on(vidA),
    .hsync(hsA), .vsync(vsA), .p_tick(ptA), .frame_start(fsA)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TICK_DIV(1)
  ) dutB (
    .clk(clk), .reset(reset), .x(xB), .y(yB), .video_on(vidB),
    .hsync(hsB), .vsync(vsB), .p_tick(ptB), .frame_start(fsB)
  );

  always #5 clk = ~clk;

  longint edgeCount = 0;
  int     assertCount = 0;
  int     failCount = 0;
  bit     checkEn = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) edgeCount <= 0;
    else       edgeCount <= edgeCount + 1;
  end

  // Expected outputs after n clk edges since reset release, from absolute time alone.
  function automatic logic [24:0] modelOut(input longint n, input int tdiv);
    longint p, m, pm;
    int     xe, ye, xm, ym;
    logic   vid, hs, vs, pt, fs;
    pt  = ((n % tdiv) == longint'(tdiv - 1));
    p   = n / tdiv;
    xe  = int'(p % HT);
    ye  = int'((p / HT) % VT);
    vid = 1'b0;
    hs  = !SA;
    vs  = !SA;
    fs  = 1'b0;
    if (n > 0) begin
      m   = n - 1;
      pm  = m / tdiv;
      xm  = int'(pm % HT);
      ym  = int'((pm / HT) % VT);
      vid = (xm < HD) && (ym < VD);
      hs  = (xm >= HD + HF && xm < HD + HF + HS) ? SA : !SA;
      vs  = (ym >= VD + VF && ym < VD + VF + VS) ? SA : !SA;
      fs  = (m > 0) && ((m % (tdiv * HT * VT)) == 0);
    end
    return {10'(xe), 10'(ye), vid, hs, vs, pt, fs};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstVal);
    @(negedge clk);
    reset = rstVal;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("modelA", 32'({xA, yA, vidA, hsA, vsA, ptA, fsA}), 32'(modelOut(edgeCount, 2)));
      checkOutput("modelB", 32'({xB, yB, vidB, hsB, vsB, ptB, fsB}), 32'(modelOut(edgeCount, 1)));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  ptCntA = 0, hsActA = 0, vidLowA = 0, vsActA = 0, fsCntA = 0, fsAtA = 0;
    int  ptCntB = 0, hsActB = 0, vsActB = 0, fsCntB = 0;
    bit  found = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rstX",   32'(xA),   32'd0);
    checkOutput("rstY",   32'(yA),   32'd0);
    checkOutput("rstVid", 32'(vidA), 32'd0);
    checkOutput("rstHs",  32'(hsA),  32'(!SA));
    checkOutput("rstVs",  32'(vsA),  32'(!SA));
    checkOutput("rstPt",  32'(ptA),  32'd0);
    checkOutput("rstFs",  32'(fsA),  32'd0);

    applyStimulus(1'b0);
    for (int i = 1; i <= 21000; i++) begin
      @(negedge clk);
      if (i <= 1600) begin
        if (ptA) ptCntA++;
        if (hsA == SA) hsActA++;
        if (!vidA) vidLowA++;
      end
      if (i <= 800) begin
        if (ptB) ptCntB++;
        if (hsB == SA) hsActB++;
      end
      if (vsA == SA) vsActA++;
      if (vsB == SA) vsActB++;
      if (fsA) begin fsCntA++; fsAtA = i; end
      if (fsB) fsCntB++;
      if (i == 1) begin
        checkOutput("vidRise", 32'(vidA), 32'd1);
        checkOutput("ptFirst", 32'(ptA),  32'd1);
      end
      if (i == 799)  checkOutput("xB799", 32'(xB), 32'd799);
      if (i == 800) begin
        checkOutput("xBwrap", 32'(xB), 32'd0);
        checkOutput("yBinc",  32'(yB), 32'd1);
      end
      if (i == 1599) checkOutput("xA799", 32'(xA), 32'd799);
      if (i == 1600) begin
        checkOutput("xAwrap", 32'(xA), 32'd0);
        checkOutput("yAinc",  32'(yA), 32'd1);
      end
    end
    checkOutput("ptCntA",  32'(ptCntA),  32'd800);
    checkOutput("hsActA",  32'(hsActA),  32'd192);
    checkOutput("vidLowA", 32'(vidLowA), 32'd320);
    checkOutput("ptCntB",  32'(ptCntB),  32'd800);
    checkOutput("hsActB",  32'(hsActB),  32'd96);
    checkOutput("vsActA",  32'(vsActA),  32'd3200);
    checkOutput("vsActB",  32'(vsActB),  32'd3200);
    checkOutput("fsCntA",  32'(fsCntA),  32'd1);
    checkOutput("fsAtA",   32'(fsAtA),   32'd20801);
    checkOutput("fsCntB",  32'(fsCntB),  32'd2);

    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (xA == 10'd400 && yA == 10'd5) found = 1'b1;
    end
    checkOutput("midFound", 32'(found), 32'd1);

    #2;
    reset = 1'b1;
    #1;
    checkOutput("midX",   32'(xA),   32'd0);
    checkOutput("midY",   32'(yA),   32'd0);
    checkOutput("midVid", 32'(vidA), 32'd0);
    checkOutput("midHs",  32'(hsA),  32'(!SA));
    checkOutput("midVs",  32'(vsA),  32'(!SA));
    checkOutput("midFs",  32'(fsA),  32'd0);
    checkOutput("midXB",  32'(xB),   32'd0);
    repeat (3) @(posedge clk);
    applyStimulus(1'b0);
    for (int i = 1; i <= 1600; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("reVid", 32'(vidA), 32'd1);
        checkOutput("reX",   32'(xA),   32'd0);
      end
      if (i == 1600) begin
        checkOutput("reXwrap", 32'(xA), 32'd0);
        checkOutput("reYinc",  32'(yA), 32'd1);
      end
    end

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
